// File: rtl/seq_det_ctrl.sv
// Serial pattern detector with a configurable pattern and an overlap mode.
// Runs until a nonzero match target is reached or the run is stopped.
module seq_det_ctrl #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             start,
  input  logic             stop,
  input  logic             x,
  input  logic             x_valid,
  output logic             z,
  output logic [CNT_W-1:0] match_count,
  output logic             busy,
  output logic             done
);

  localparam int FW = $clog2(PAT_W);
  localparam logic [7:0] PAT_RST = 8'b0000_1011;
  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PAT_W-1:0]   pattern_q, pattern_d;
  logic               overlap_q, overlap_d;
  logic [CNT_W-1:0]   target_q, target_d;
  logic [PAT_W-2:0]   hist_q, hist_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [PAT_W-1:0]   cand;
  logic [CNT_W-1:0]   cnt_inc;
  logic               hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pattern_q <= PAT_RST[PAT_W-1:0];
      overlap_q <= 1'b1;
      target_q  <= '0;
      hist_q    <= '0;
      fill_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      overlap_q <= overlap_d;
      target_q  <= target_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    overlap_d = overlap_q;
    target_d  = target_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    cnt_d     = cnt_q;

    cand    = {hist_q, x};
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    hit     = (state_q == S_RUN) && x_valid && (fill_q == FILL_MAX) && (cand == pattern_q);

    unique case (state_q)
      S_IDLE, S_DONE: begin
        // cfg_ready is high here, so cfg_valid alone is a transfer and beats start
        if (cfg_valid) begin
          pattern_d = cfg_pattern;
          overlap_d = cfg_overlap;
          target_d  = cfg_target;
          state_d   = S_IDLE;
        end else if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          fill_d  = '0;
        end
      end
      S_RUN: begin
        if (x_valid) begin
          hist_d = cand[PAT_W-2:0];
          fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + FW'(1);
        end
        if (hit) begin
          cnt_d = cnt_inc;
          if (!overlap_q) fill_d = '0;
        end
        // a match coincident with stop is counted first and may still finish the run
        if (hit && (target_q != '0) && (cnt_inc == target_q)) state_d = S_DONE;
        else if (stop)                                        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cfg_ready   = reset || (state_q != S_RUN);
  assign z           = !reset && hit;
  assign busy        = !reset && (state_q == S_RUN);
  assign done        = !reset && (state_q == S_DONE);
  assign match_count = reset ? '0 : cnt_q;

endmodule
